// File: rtl/sid_bridge_pkg.sv
// Shared constants and types for the SPI-to-SID register bridge.
// Byte classes: 1AAAAADD header, 00DDDDDD data, 01C000SS select/clear.
package sid_bridge_pkg;

  localparam int         HDR_BIT = 7;
  localparam logic [1:0] SEL_TAG = 2'b01;
  localparam logic [1:0] DAT_TAG = 2'b00;
  localparam int         CLR_BIT = 5;

  // Register write payload.
  // A queued entry is {chip, sid_wr_t}; the chip field width depends on NUM_SIDS.
  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } sid_wr_t;

  // Width of the chip-select field; a single SID still uses one bit.
  function automatic int chip_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sid_bridge_fifo.sv
// Synchronous write-queue FIFO with occupancy output.
// Pushes when full and pops when empty are ignored.
module sid_bridge_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sid_spi_bridge.sv
// SPI command decoder, write queue and SID bus issue logic plus the SID clock enable.
// Optional: define SID_BRIDGE_SYNC_EN to pace bus writes on clk_en.
module sid_spi_bridge
  import sid_bridge_pkg::*;
#(
  parameter int NUM_SIDS   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    spi_data,
  input  logic                          spi_recv,
  output logic                          clk_en,
  output logic [NUM_SIDS-1:0]           bus_we,
  output logic [4:0]                    bus_addr,
  output logic [7:0]                    bus_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int CW   = chip_w(NUM_SIDS);
  localparam int CNTW = $clog2(CLK_DIV);

  typedef struct packed {
    logic [CW-1:0] chip;
    sid_wr_t       wr;
  } entry_t;

  typedef enum logic {IDLE, STROBE} state_t;

  // SID clock enable
  logic [CNTW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_cnt <= CNTW'(CLK_DIV-1);
    else if (div_cnt == '0)  div_cnt <= CNTW'(CLK_DIV-1);
    else                     div_cnt <= div_cnt - 1'b1;
  end

  assign clk_en = (div_cnt == '0);

  // Byte decoder
  logic          hdr_valid;
  logic [4:0]    addr_q;
  logic [1:0]    msb_q;
  logic [CW-1:0] chip_sel;
  logic          is_hdr, is_dat, sel_ok, push;
  logic          fifo_full, fifo_empty;
  entry_t        din, head;

  assign is_hdr = spi_data[HDR_BIT];
  assign is_dat = (spi_data[7:6] == DAT_TAG);
  assign sel_ok = (spi_data[4:2] == 3'b000) && (int'(spi_data[1:0]) < NUM_SIDS);
  assign push   = spi_recv && is_dat && hdr_valid;

  always_comb begin
    din         = '0;
    din.chip    = chip_sel;
    din.wr.addr = addr_q;
    din.wr.data = {msb_q, spi_data[5:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_valid <= 1'b0;
      addr_q    <= '0;
      msb_q     <= '0;
      chip_sel  <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (spi_recv) begin
      if (is_hdr) begin
        addr_q    <= spi_data[6:2];
        msb_q     <= spi_data[1:0];
        hdr_valid <= 1'b1;
      end else if (is_dat) begin
        if (!hdr_valid)     frame_err <= 1'b1;
        else if (fifo_full) overflow  <= 1'b1;
      end else begin
        if (sel_ok) chip_sel <= spi_data[CW-1:0];
        // Clear wins over an error raised by the same select byte.
        if (spi_data[CLR_BIT]) begin
          overflow  <= 1'b0;
          frame_err <= 1'b0;
        end else if (!sel_ok) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  // Issue FSM
  state_t        state, state_nx;
  logic          pop;
  logic [CW-1:0] chip_q;

  sid_bridge_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
`ifdef SID_BRIDGE_SYNC_EN
        pop = clk_en && !fifo_empty;
`else
        pop = !fifo_empty;
`endif
        if (pop) state_nx = STROBE;
      end
      STROBE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus address/data hold the last popped entry until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_q   <= '0;
      bus_addr <= '0;
      bus_data <= '0;
    end else if (pop) begin
      chip_q   <= head.chip;
      bus_addr <= head.wr.addr;
      bus_data <= head.wr.data;
    end
  end

  always_comb begin
    bus_we = '0;
    for (int i = 0; i < NUM_SIDS; i++)
      bus_we[i] = (state == STROBE) && (chip_q == CW'(i));
  end

endmodule

// File: tb/tb_sid_spi_bridge.sv
// Scoreboard bench for sid_spi_bridge (NUM_SIDS=2, FIFO_DEPTH=8, CLK_DIV=12).
module tb_sid_spi_bridge;

  localparam int NS = 2;
  localparam int FD = 8;
  localparam int CD = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spi_data = '0;
  logic       spi_recv = 1'b0;
  logic          clk_en;
  logic [NS-1:0] bus_we;
  logic [4:0]    bus_addr;
  logic [7:0]    bus_data;
  logic [3:0]    fifo_level;
  logic          overflow, frame_err;

  sid_spi_bridge #(.NUM_SIDS(NS), .FIFO_DEPTH(FD), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .spi_data(spi_data), .spi_recv(spi_recv),
    .clk_en(clk_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_data(bus_data),
    .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] we;
    logic [4:0]    addr;
    logic [7:0]    data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0, n_wr = 0, peak = 0;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && bus_we != '0) begin
      n_wr++;
      if (sb.size() == 0) chk("we_unexpected", 32'(bus_we), 0);
      else begin
        mon_e = sb.pop_front();
        chk("we",   32'(bus_we),   32'(mon_e.we));
        chk("addr", 32'(bus_addr), 32'(mon_e.addr));
        chk("data", 32'(bus_data), 32'(mon_e.data));
`ifdef SID_BRIDGE_SYNC_EN
        chk("we_after_clk_en", 32'(prev_en), 1);
`endif
      end
    end
    if (32'(fifo_level) > peak) peak = 32'(fifo_level);
    prev_en = clk_en;
  end

  task automatic send(input logic [7:0] b);
    spi_data = b;
    spi_recv = 1'b1;
    @(posedge clk);
    #1 spi_recv = 1'b0;
  endtask

  task automatic expect_wr(input int chip, input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    e.we   = NS'(1 << chip);
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_left", 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_we",    32'(bus_we), 0);
    chk("rst_level", 32'(fifo_level), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Start a burst in the cycle right after a clk_en pulse.
  task automatic align_en();
    bit found = 0;
    for (int i = 0; i < 3*CD && !found; i++) begin
      @(negedge clk);
      if (clk_en) found = 1;
    end
    if (!found) chk("clk_en_align", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_en",   32'(clk_en), 0);
    chk("rst_bus_we",   32'(bus_we), 0);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_bus_data", 32'(bus_data), 0);
    chk("rst_level",    32'(fifo_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;

    // clk_en cadence from reset release (release cycle is cycle 0)
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("clk_en_c%0d", k), 32'(clk_en), 32'(k == 11 || k == 23 || k == 35));
    end

    // Header + data to chip 0
    @(posedge clk);
    #1;
    send(8'h86);
    expect_wr(0, 5'd1, 8'h95);
    send(8'h15);
`ifndef SID_BRIDGE_SYNC_EN
    @(negedge clk);
    chk("lat_level_t1", 32'(fifo_level), 1);
    chk("lat_we_t1",    32'(bus_we), 0);
    @(negedge clk);
    chk("lat_we_t2",    32'(bus_we), 1);
`endif
    drain(60);

    // Chip 1, top address, header reuse
    send(8'h41);
    send(8'hFC);
    expect_wr(1, 5'd31, 8'h3F);
    send(8'h3F);
    expect_wr(1, 5'd31, 8'h00);
    send(8'h00);
    drain(60);

    // Framing errors and select/clear
    do_reset();
    send(8'h05);
    @(negedge clk);
    chk("fe_no_hdr", 32'(frame_err), 1);
    chk("no_hdr_level", 32'(fifo_level), 0);
    send(8'h60);
    @(negedge clk);
    chk("fe_cleared", 32'(frame_err), 0);
    send(8'h43);
    @(negedge clk);
    chk("fe_bad_ss", 32'(frame_err), 1);
    send(8'h84);
    expect_wr(0, 5'd1, 8'h01);
    send(8'h01);
    drain(60);
    send(8'h60);
    send(8'h41);
    @(negedge clk);
    chk("fe_sel_ok", 32'(frame_err), 0);
    send(8'h45);
    @(negedge clk);
    chk("fe_bad_bits", 32'(frame_err), 1);
    send(8'h80);
    expect_wr(1, 5'd0, 8'h2A);
    send(8'h2A);
    drain(60);

    // FIFO overflow burst
    peak = 0;
    w0 = n_wr;
`ifdef SID_BRIDGE_SYNC_EN
    align_en();
    send(8'h88);
    for (int d = 1; d <= 10; d++) begin
      if (d <= 8) expect_wr(1, 5'd2, 8'(d));
      send(8'(d));
    end
    @(negedge clk);
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_flag",  32'(overflow), 1);
    drain(150);
    chk("ovf_writes", 32'(n_wr - w0), 8);
`else
    send(8'h88);
    for (int d = 1; d <= 16; d++) begin
      if (d <= 15) expect_wr(1, 5'd2, 8'(d));
      send(8'(d));
    end
    @(negedge clk);
    chk("ovf_flag", 32'(overflow), 1);
    drain(60);
    chk("ovf_writes", 32'(n_wr - w0), 15);
`endif
    chk("ovf_peak", 32'(peak), 8);
    send(8'h60);
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 0);

    // Reset mid-stream discards queued writes
    w0 = n_wr;
`ifdef SID_BRIDGE_SYNC_EN
    align_en();
`endif
    send(8'h88);
    for (int d = 1; d <= 4; d++) begin
      expect_wr(0, 5'd2, 8'(d + 32));
      send(8'(d + 32));
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    32'(bus_we), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
`ifdef SID_BRIDGE_SYNC_EN
    chk("mid_rst_writes", 32'(n_wr - w0), 0);
`else
    chk("mid_rst_writes", 32'(n_wr - w0), 1);
`endif
    chk("post_rst_level", 32'(fifo_level), 0);
    chk("post_rst_fe",    32'(frame_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
